// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 pipelined multiplexer family.
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;  // grant follows the external select port
  localparam int MUX_MODE_RR  = 1;  // grant rotates over valid inputs

  // Select width that stays at least one bit wide for a single-input mux.
  function automatic int mux_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry FIFO holding {source, data} payloads; head is presented downstream.
module skid_buffer_2 #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [1:0]    o_count,
  output logic          o_valid,
  output logic [DW-1:0] o_head
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_count;

  // Head/tail shuffle: a pop promotes the tail, a push fills the first free slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count unchanged; with one entry the new word replaces the head.
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_head  = r_head;

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// N-input registered multiplexer with valid/ready handshakes on both sides.
// Grant is either the select port or a round-robin scan; the chosen word is
// pushed into a two-entry skid buffer whose head drives the output.
module mux_n_to_1_pipe
  import mux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32,
  parameter int MODE  = MUX_MODE_SEL,
  parameter int SEL_W = mux_sel_w(N_IN)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [N_IN-1:0]       i_in_valid,
  input  logic [N_IN*WIDTH-1:0] i_in_data,
  output logic [N_IN-1:0]       o_in_ready,
  output logic                  o_out_valid,
  output logic [WIDTH-1:0]      o_out_data,
  output logic [SEL_W-1:0]      o_out_src,
  input  logic                  i_out_ready
);

  logic [SEL_W-1:0]       r_rr_ptr;
  logic                   w_gnt_vld;
  logic [SEL_W-1:0]       w_gnt;
  int                     w_idx;
  logic                   w_can_push;
  logic                   w_push;
  logic                   w_pop;
  logic [WIDTH-1:0]       w_data;
  logic [1:0]             w_count;
  logic                   w_valid;
  logic [SEL_W+WIDTH-1:0] w_head;

  // Grant: select port in MODE 0, first valid channel after rr_ptr in MODE 1.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    if (N_IN == 1) begin
      w_gnt_vld = 1'b1;
    end else if (MODE == MUX_MODE_SEL) begin
      if (int'(i_sel) < N_IN) begin
        w_gnt_vld = 1'b1;
        w_gnt     = i_sel;
      end
    end else begin
      for (int k = 1; k <= N_IN; k++) begin
        w_idx = (int'(r_rr_ptr) + k) % N_IN;
        if (!w_gnt_vld && i_in_valid[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_idx[SEL_W-1:0];
        end
      end
    end
  end

  // Room depends only on buffer occupancy, never on i_out_ready.
  assign w_can_push = (w_count < 2'd2) && !i_reset;

  // One-hot ready toward the granted channel and the matching data word.
  always_comb begin
    o_in_ready = '0;
    w_data     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_gnt == SEL_W'(i)) begin
        o_in_ready[i] = w_gnt_vld && w_can_push;
        w_data        = i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_push = |(i_in_valid & o_in_ready);
  assign w_pop  = w_valid & i_out_ready;

  // Round-robin pointer moves only when a word is actually accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_rr_ptr <= SEL_W'(N_IN - 1);
    else if (w_push) r_rr_ptr <= w_gnt;
  end

  skid_buffer_2 #(
    .DW (SEL_W + WIDTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({w_gnt, w_data}),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_head  (w_head)
  );

  assign o_out_valid = w_valid;
  assign o_out_data  = w_head[WIDTH-1:0];
  assign o_out_src   = w_head[WIDTH +: SEL_W];

endmodule
